prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: PROG_LOADER

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16, instruction word width; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_SIZE, default 4, program memory address width (2**ADDR_SIZE words).
REQ-003 SHALL have port clk  input  1  system clock, posedge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port START  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port LEN  input  ADDR_SIZE+1  number of words to load, sampled on accepted START.
REQ-007 SHALL have port BYTE_IN  input  8  incoming program byte.
REQ-008 SHALL have port BYTE_VALID  input  1  BYTE_IN valid.
REQ-009 SHALL have port BYTE_READY  output  1  loader accepts BYTE_IN this cycle.
REQ-010 SHALL have port W  output  1  program memory write enable.
REQ-011 SHALL have port DATA_WR  output  DATA_SIZE  program memory write data.
REQ-012 SHALL have port ADDR  output  ADDR_SIZE  program memory address.
REQ-013 SHALL have port BUSY  output  1  load in progress.
REQ-014 SHALL have port DONE  output  1  one-cycle pulse at load completion.

Function
REQ-015 SHALL implement FSM states IDLE, RECV, WRITE, FINISH.
REQ-016 IDLE: START=1 -> latch LEN (clamped to 2**ADDR_SIZE), clear word count and byte index; LEN=0 -> FINISH, else -> RECV.
REQ-017 START SHALL be ignored in every state other than IDLE.
REQ-018 BYTE_READY SHALL be 1 only in RECV; a byte is accepted on a posedge with BYTE_VALID=1 and BYTE_READY=1.
REQ-019 Bytes SHALL assemble little-endian: k-th accepted byte of a word -> DATA_WR bits [8k+7:8k].
REQ-020 After accepting byte DATA_SIZE/8-1 of a word, the next state SHALL be WRITE; BYTE_VALID=0 in RECV holds state with no change.
REQ-021 WRITE SHALL last exactly one cycle with W=1, ADDR=word count, DATA_WR=assembled word, BYTE_READY=0.
REQ-022 Leaving WRITE: word count incremented; count==latched LEN -> FINISH, else -> RECV with byte index 0.
REQ-023 FINISH SHALL last one cycle with DONE=1, then -> IDLE.
REQ-024 W SHALL be 0 in every state except WRITE; memory is never written during RECV.
REQ-025 BUSY SHALL be 1 in RECV, WRITE and FINISH, 0 in IDLE.
REQ-026 ADDR SHALL equal the current word count in all states; wraps to 0 only after a full 2**ADDR_SIZE-word load ends.
REQ-027 Latency: last byte accepted at edge N -> W=1 in cycle N+1; final word -> DONE=1 in cycle N+2.
REQ-028 W, DATA_WR, ADDR, DONE, BUSY SHALL be driven from registers/state only, with no combinational path from inputs.

Reset
REQ-029 rstn=0 SHALL force IDLE asynchronously, and clear word count, byte index, DATA_WR, ADDR to 0.
REQ-030 While rstn=0, W, DONE, BUSY and BYTE_READY SHALL all be 0.
REQ-031 Reset mid-load SHALL discard the partial word and issue no write; loading resumes only on a new START.

Verification
REQ-032 START, LEN=2, bytes 34,12,CD,AB back-to-back -> W pulses: ADDR=0 DATA_WR=1234, ADDR=1 DATA_WR=ABCD; DONE one cycle after second W; BUSY 0 afterwards.
REQ-033 START, LEN=0 -> DONE=1 in the cycle after START, no W pulse, BYTE_READY never 1.
REQ-034 LEN=1, BYTE_VALID gapped with 3 idle cycles between the two bytes -> single W with DATA_WR=byte2:byte1 and no extra writes.
REQ-035 LEN=31 with ADDR_SIZE=4 -> clamped to 16 writes at ADDR 0..15, then DONE; second START during BUSY ignored.
REQ-036 LEN=2; rstn pulsed low after the 3rd byte -> no second W, BUSY=0; new START LEN=1, bytes 01,00 -> W at ADDR=0 with DATA_WR=0001.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: collects a byte stream little-endian into DATA_SIZE-bit
// words and writes each one to consecutive program memory addresses.
// Every output is decoded from registered state only.
module prog_loader #(
   parameter int DATA_SIZE = 16,
   parameter int ADDR_SIZE = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 START,
   input  logic [ADDR_SIZE:0]   LEN,
   input  logic [7:0]           BYTE_IN,
   input  logic                 BYTE_VALID,
   output logic                 BYTE_READY,
   output logic                 W,
   output logic [DATA_SIZE-1:0] DATA_WR,
   output logic [ADDR_SIZE-1:0] ADDR,
   output logic                 BUSY,
   output logic                 DONE
);

   localparam int unsigned BYTES  = DATA_SIZE / 8;
   localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   localparam logic [BIDX_W-1:0]  LAST_BYTE = BIDX_W'(BYTES - 1);
   localparam logic [ADDR_SIZE:0] MAX_LEN   = {1'b1, {ADDR_SIZE{1'b0}}};

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RECV   = 2'd1;
   localparam logic [1:0] S_WRITE  = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [ADDR_SIZE:0]   len_q,   len_d;
   logic [ADDR_SIZE:0]   cnt_q,   cnt_d;
   logic [BIDX_W-1:0]    bidx_q,  bidx_d;
   logic [DATA_SIZE-1:0] data_q,  data_d;
   logic [ADDR_SIZE:0]   cnt_inc;

   // Next-state logic: load sequencing, byte assembly and word counting
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      bidx_d  = bidx_q;
      data_d  = data_q;
      cnt_inc = cnt_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               len_d   = (LEN > MAX_LEN) ? MAX_LEN : LEN;
               cnt_d   = '0;
               bidx_d  = '0;
               state_d = (LEN == '0) ? S_FINISH : S_RECV;
            end
         end
         S_RECV: begin
            if (BYTE_VALID) begin
               for (int unsigned k = 0; k < BYTES; k++) begin
                  if (bidx_q == BIDX_W'(k)) begin
                     data_d[8*k +: 8] = BYTE_IN;
                  end
               end
               if (bidx_q == LAST_BYTE) begin
                  state_d = S_WRITE;
               end else begin
                  bidx_d = bidx_q + 1'b1;
               end
            end
         end
         S_WRITE: begin
            cnt_d   = cnt_inc;
            bidx_d  = '0;
            state_d = (cnt_inc == len_q) ? S_FINISH : S_RECV;
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         bidx_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         bidx_q  <= bidx_d;
         data_q  <= data_d;
      end
   end

   // Output decode; the address wraps naturally once the count reaches 2**ADDR_SIZE
   always_comb begin
      BYTE_READY = (state_q == S_RECV);
      W          = (state_q == S_WRITE);
      DONE       = (state_q == S_FINISH);
      BUSY       = (state_q != S_IDLE);
      ADDR       = cnt_q[ADDR_SIZE-1:0];
      DATA_WR    = data_q;
   end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: vector table, corner sequences and
// randomized loads compared against a word-list reference model.
module tb_prog_loader;

   localparam int DW   = 16;
   localparam int AW   = 4;
   localparam int BPW  = DW / 8;
   localparam int MAXW = 1 << AW;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          START = 1'b0;
   logic [AW:0]   LEN = '0;
   logic [7:0]    BYTE_IN = '0;
   logic          BYTE_VALID = 1'b0;
   logic          BYTE_READY;
   logic          W;
   logic [DW-1:0] DATA_WR;
   logic [AW-1:0] ADDR;
   logic          BUSY;
   logic          DONE;

   always #5 clk = ~clk;

   prog_loader #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .START      (START),
      .LEN        (LEN),
      .BYTE_IN    (BYTE_IN),
      .BYTE_VALID (BYTE_VALID),
      .BYTE_READY (BYTE_READY),
      .W          (W),
      .DATA_WR    (DATA_WR),
      .ADDR       (ADDR),
      .BUSY       (BUSY),
      .DONE       (DONE)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int ready_cnt = 0;
   int start_c = 0;

   int            wa[$];
   logic [DW-1:0] wd[$];
   int            wc[$];
   int            dc[$];
   logic [7:0]    bq[$];
   int            acc_c[$];

   typedef struct {
      int            len;
      int            gap;
      int            n_exp;
      logic [31:0]   bytes;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Per-cycle observation: record writes/done pulses and check output relations
   task automatic sample();
      logic ok;
      if (W) begin
         wa.push_back(int'(ADDR));
         wd.push_back(DATA_WR);
         wc.push_back(cyc);
      end
      if (DONE) dc.push_back(cyc);
      if (BYTE_READY) ready_cnt++;
      ok = !(W && BYTE_READY) && !(W && DONE) && !(DONE && BYTE_READY) &&
           (BUSY || !(W || DONE || BYTE_READY));
      if (!rstn) ok = ok && !W && !DONE && !BUSY && !BYTE_READY &&
                      (ADDR == '0) && (DATA_WR == '0);
      chk("cycle_invariants", {31'd0, ok}, 32'd1);
   endtask

   // Advance one clock; returns 1 time unit after the rising edge
   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_capture();
      wa.delete();
      wd.delete();
      wc.delete();
      dc.delete();
      acc_c.delete();
      ready_cnt = 0;
   endtask

   task automatic start_load(input int len);
      clear_capture();
      LEN        = (AW+1)'(len);
      START      = 1'b1;
      BYTE_VALID = 1'b0;
      start_c    = cyc;
      tick();
      START      = 1'b0;
   endtask

   // gap>0: fixed idle cycles after each accepted byte; gap<0: random gaps
   task automatic feed(input int total, input int gap, input bit inject);
      int fed;
      int gap_left;
      bit v;
      bit r;
      fed = 0;
      gap_left = 0;
      for (int t = 0; t < 3000 && fed < total; t++) begin
         if (gap_left > 0) begin
            v = 1'b0;
            gap_left--;
         end else if (gap < 0) begin
            v = ($urandom_range(0, 2) != 0);
         end else begin
            v = 1'b1;
         end
         r = BYTE_READY;
         BYTE_VALID = v;
         BYTE_IN    = v ? bq[fed] : 8'($urandom);
         if (inject && BUSY && $urandom_range(0, 3) == 0) begin
            START = 1'b1;
            LEN   = (AW+1)'($urandom_range(0, 31));
         end else begin
            START = 1'b0;
         end
         tick();
         if (v && r) begin
            acc_c.push_back(cyc - 1);
            fed++;
            if (gap > 0) gap_left = gap;
         end
      end
      BYTE_VALID = 1'b0;
      START      = 1'b0;
      chk("bytes_accepted", 32'(fed), 32'(total));
   endtask

   task automatic wait_done();
      for (int t = 0; t < 40 && dc.size() == 0; t++) tick();
      repeat (3) tick();
   endtask

   // Reference model: word i = bytes i*BPW.. little-endian at address i,
   // written the cycle after its last byte, DONE one cycle after the last write
   task automatic check_load(input int len);
      int nw;
      logic [DW-1:0] exp;
      nw = (len > MAXW) ? MAXW : len;
      chk("write_count", 32'(wa.size()), 32'(nw));
      for (int i = 0; i < nw && i < wa.size(); i++) begin
         exp = '0;
         for (int b = 0; b < BPW; b++) exp[8*b +: 8] = bq[i*BPW + b];
         chk("write_addr", 32'(wa[i]), 32'(i));
         chk("write_data", 32'(wd[i]), 32'(exp));
         chk("write_cycle", 32'(wc[i]), 32'(acc_c[i*BPW + BPW - 1] + 1));
      end
      chk("done_count", 32'(dc.size()), 32'd1);
      if (dc.size() > 0)
         chk("done_cycle", 32'(dc[0]), 32'((nw == 0) ? start_c + 1 : acc_c[nw*BPW - 1] + 2));
      if (nw == 0) chk("ready_never", 32'(ready_cnt), 32'd0);
      chk("busy_after", 32'(BUSY), 32'd0);
      chk("addr_after", 32'(ADDR), 32'(nw % MAXW));
   endtask

   task automatic run_load(input int len, input int gap, input bit inject);
      int nw;
      nw = (len > MAXW) ? MAXW : len;
      start_load(len);
      feed(nw * BPW, gap, inject);
      wait_done();
      check_load(len);
   endtask

   initial begin
      logic [31:0] bb;
      int len;
      int g;

      vecs[0] = '{2, 0, 2, 32'hABCD1234, 16'h1234, 16'hABCD};
      vecs[1] = '{0, 0, 0, 32'h00000000, 16'h0000, 16'h0000};
      vecs[2] = '{1, 3, 1, 32'h0000C35A, 16'hC35A, 16'h0000};
      vecs[3] = '{1, 1, 1, 32'h000000FF, 16'h00FF, 16'h0000};
      vecs[4] = '{2, 2, 2, 32'h7F018000, 16'h8000, 16'h7F01};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 32'({ADDR, DATA_WR, W, DONE, BUSY, BYTE_READY}), 32'd0);
      rstn = 1'b1;
      tick();

      // Vector table
      for (int v = 0; v < 5; v++) begin
         bb = vecs[v].bytes;
         bq.delete();
         for (int b = 0; b < 4; b++) bq.push_back(bb[8*b +: 8]);
         run_load(vecs[v].len, vecs[v].gap, 1'b0);
         chk("vec_nwrites", 32'(wa.size()), 32'(vecs[v].n_exp));
         if (wa.size() > 0 && vecs[v].n_exp > 0) chk("vec_d0", 32'(wd[0]), 32'(vecs[v].d0));
         if (wa.size() > 1 && vecs[v].n_exp > 1) chk("vec_d1", 32'(wd[1]), 32'(vecs[v].d1));
         tick();
      end

      // LEN above capacity clamps to a full memory; START while busy is ignored
      bq.delete();
      for (int b = 0; b < MAXW * BPW; b++) bq.push_back(8'($urandom));
      run_load(31, -1, 1'b1);
      chk("clamp_writes", 32'(wa.size()), 32'(MAXW));
      tick();

      // Reset in the middle of the second word
      bq.delete();
      bq.push_back(8'h34); bq.push_back(8'h12); bq.push_back(8'hCD); bq.push_back(8'hAB);
      start_load(2);
      feed(3, 0, 1'b0);
      rstn = 1'b0;
      #2;
      chk("reset_async", 32'({ADDR, DATA_WR, W, DONE, BUSY, BYTE_READY}), 32'd0);
      tick();
      tick();
      rstn = 1'b1;
      repeat (5) tick();
      chk("reset_writes", 32'(wa.size()), 32'd1);
      chk("reset_no_done", 32'(dc.size()), 32'd0);
      chk("reset_busy", 32'(BUSY), 32'd0);
      bq.delete();
      bq.push_back(8'h01); bq.push_back(8'h00);
      run_load(1, 0, 1'b0);
      if (wa.size() > 0) begin
         chk("post_reset_addr", 32'(wa[0]), 32'd0);
         chk("post_reset_data", 32'(wd[0]), 32'h0001);
      end
      tick();

      // Randomized loads against the reference model
      for (int r = 0; r < 12; r++) begin
         len = int'($urandom_range(0, 31));
         g   = int'($urandom_range(0, 3));
         if (g == 3) g = -1;
         bq.delete();
         for (int b = 0; b < MAXW * BPW; b++) bq.push_back(8'($urandom));
         run_load(len, g, 1'($urandom_range(0, 1)));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
